led_out_port: RTL

LED_OUT_PORT -- requirements
Module: led_out_port

---
 rtl/led_out_port.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/led_out_port.sv
// LED output port on a Z80-style I/O bus: an 8-bit LED register with read-back.
// Latency: the bus strobes are synchronized before use, so a write reaches Led on the 3rd mclk edge after the strobes fall.
// Backpressure: none. The FSM waits in HOLD until iorq_n is released, so each bus cycle writes at most once.
// Optional feature: define LED_BLINK_EN to add a blink_mask register at PORT_ADDR+1 and a BLINK_DIV blink counter.
// Ports: mclk, rst_n (async, active low); iorq_n/wr_n/rd_n/addr/data_in (bus inputs);
//        data_out/data_oe (read-back to the bus); Led (LED drive, 1 = lit).
module led_out_port #(
  parameter logic [7:0] PORT_ADDR = 8'h01,
  parameter int         BLINK_DIV = 25000000
) (
  input  logic       mclk,
  input  logic       rst_n,
  input  logic       iorq_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [7:0] Led
);

  if (BLINK_DIV < 2) begin : g_bad_div
    $error("BLINK_DIV must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, WRITE, READ, HOLD} state_t;

  state_t     state, next_state;
  logic [1:0] iorq_sync, wr_sync, rd_sync;
  logic       iorq_s, wr_s, rd_s;
  logic [7:0] led_reg;
  logic       hit_led, hit, ld_led;

  // The synchronizers reset to 1 so that the strobes read as inactive.
  // A bus cycle that is still active when reset is released is therefore
  // seen only after it has passed through both flops.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      iorq_sync <= 2'b11;
      wr_sync   <= 2'b11;
      rd_sync   <= 2'b11;
    end else begin
      iorq_sync <= {iorq_sync[0], iorq_n};
      wr_sync   <= {wr_sync[0], wr_n};
      rd_sync   <= {rd_sync[0], rd_n};
    end
  end

  assign iorq_s = iorq_sync[1];
  assign wr_s   = wr_sync[1];
  assign rd_s   = rd_sync[1];

  assign hit_led = (addr == PORT_ADDR);

`ifdef LED_BLINK_EN
  localparam logic [7:0] MASK_ADDR = PORT_ADDR + 8'd1;
  localparam int         CW        = $clog2(BLINK_DIV);

  logic          hit_mask, ld_mask, sel_mask_q, sample, phase;
  logic [7:0]    blink_mask;
  logic [CW-1:0] cnt;

  assign hit_mask = (addr == MASK_ADDR);
  assign hit      = hit_led | hit_mask;

  // The blink counter runs freely. Writes to blink_mask do not disturb it.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == CW'(BLINK_DIV - 1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      blink_mask <= 8'h00;
      sel_mask_q <= 1'b0;
    end else begin
      if (ld_mask) blink_mask <= data_in;
      // Remember which register the bus cycle addressed, for read-back in READ.
      if (sample)  sel_mask_q <= hit_mask;
    end
  end

  assign Led = led_reg & ~(blink_mask & {8{phase}});
`else
  assign hit = hit_led;
  assign Led = led_reg;
`endif

  // Data is taken from the bus in the same cycle the FSM leaves IDLE. The
  // load lands on the edge that enters WRITE, which gives the 3-edge latency.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) led_reg <= 8'h00;
    else if (ld_led) led_reg <= data_in;
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    data_oe    = 1'b0;
    data_out   = 8'h00;
    ld_led     = 1'b0;
`ifdef LED_BLINK_EN
    ld_mask    = 1'b0;
    sample     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!iorq_s) begin
`ifdef LED_BLINK_EN
          sample = 1'b1;
`endif
          if (hit && !wr_s && rd_s) begin
            next_state = WRITE;
            ld_led     = hit_led;
`ifdef LED_BLINK_EN
            ld_mask    = hit_mask;
`endif
          end else if (hit && !rd_s && wr_s) begin
            next_state = READ;
          end else if (!hit || (!wr_s && !rd_s)) begin
            next_state = HOLD;
          end
          // If the address decodes but neither wr_n nor rd_n is low yet,
          // stay in IDLE and wait for a strobe.
        end
      end
      WRITE: next_state = HOLD;
      READ: begin
        data_oe = 1'b1;
`ifdef LED_BLINK_EN
        data_out = sel_mask_q ? blink_mask : led_reg;
`else
        data_out = led_reg;
`endif
        if (iorq_s || rd_s) next_state = IDLE;
      end
      HOLD: if (iorq_s) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

endmodule
